// File: rtl/rv_arb_pkg.sv
// Shared types and reset constants for the unified memory port arbiter.
// RV_ARB_RR_EN selects round-robin arbitration in rv_mem_arb.
package rv_arb_pkg;

  typedef enum logic {
    ARB_IDLE    = 1'b0,
    ARB_RD_WAIT = 1'b1
  } arb_state_t;

  typedef enum logic {
    OWN_CORE = 1'b0,
    OWN_EXT  = 1'b1
  } arb_owner_t;

  localparam arb_state_t STATE_RST    = ARB_IDLE;
  localparam arb_owner_t OWNER_RST    = OWN_CORE;
  localparam arb_owner_t LAST_WIN_RST = OWN_EXT;

  // Bit 0 is the core grant, bit 1 the external grant.
  function automatic logic [1:0] grantVec(input arb_owner_t winner);
    return (winner == OWN_EXT) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rv_mem_arb_if.sv
// Requester handshakes plus the memory port of the arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface rv_mem_arb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;

  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic              ext_rvalid;

  logic [DATA_W-1:0] rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_gnt, ext_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_gnt, ext_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/rv_arb_pick.sv
// Combinational winner selection; grants only in IDLE and only while enabled.
// i_extBias means "ext wins contention": wait saturation, or core won last (RV_ARB_RR_EN).
module rv_arb_pick
  import rv_arb_pkg::*;
(
  input  logic       i_enable,
  input  logic       i_coreReq,
  input  logic       i_extReq,
  input  logic       i_extBias,
  input  arb_state_t i_state,
  output logic [1:0] o_gnt,
  output arb_owner_t o_winner
);

  always_comb begin
    o_gnt    = 2'b00;
    o_winner = OWN_CORE;
    if (i_enable && (i_state == ARB_IDLE) && (i_coreReq || i_extReq)) begin
      if (i_extReq && (!i_coreReq || i_extBias)) begin
        o_winner = OWN_EXT;
      end else begin
        o_winner = OWN_CORE;
      end
      o_gnt = grantVec(o_winner);
    end
  end

endmodule

// File: rtl/rv_mem_arb.sv
// Two-requester arbiter for the unified memory port of the multicycle RISC-V model.
// Define RV_ARB_RR_EN for round-robin; otherwise fixed core priority with a starvation guard.
module rv_mem_arb
  import rv_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  rv_mem_arb_if.slave     bus
);

  arb_state_t r_state;
  arb_state_t w_nextState;
  arb_owner_t r_owner;
  arb_owner_t w_winner;
  logic [1:0] w_gnt;
  logic       w_extBias;
  logic       w_winWe;

  rv_arb_pick u_pick (
    .i_enable  (rst_n),
    .i_coreReq (bus.core_req),
    .i_extReq  (bus.ext_req),
    .i_extBias (w_extBias),
    .i_state   (r_state),
    .o_gnt     (w_gnt),
    .o_winner  (w_winner)
  );

  assign w_winWe = (w_winner == OWN_EXT) ? bus.ext_we : bus.core_we;

`ifdef RV_ARB_RR_EN
  arb_owner_t r_lastWin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lastWin <= LAST_WIN_RST;
    end else if (|w_gnt) begin
      r_lastWin <= w_winner;
    end
  end

  assign w_extBias = (r_lastWin == OWN_CORE);
`else
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_SAT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_waitCnt;

  // Counts cycles the external side has been left waiting; saturation forces its grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_waitCnt <= '0;
    end else if (!bus.ext_req || w_gnt[1]) begin
      r_waitCnt <= '0;
    end else if (r_waitCnt != WAIT_SAT) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  assign w_extBias = (r_waitCnt == WAIT_SAT);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= STATE_RST;
      r_owner <= OWNER_RST;
    end else begin
      r_state <= w_nextState;
      if ((|w_gnt) && !w_winWe) begin
        r_owner <= w_winner;
      end
    end
  end

  always_comb begin
    w_nextState     = r_state;
    bus.core_gnt    = w_gnt[0];
    bus.ext_gnt     = w_gnt[1];
    bus.core_rvalid = 1'b0;
    bus.ext_rvalid  = 1'b0;
    bus.rdata       = '0;
    bus.mem_en      = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    case (r_state)
      ARB_IDLE: begin
        if (|w_gnt) begin
          bus.mem_en = 1'b1;
          bus.mem_we = w_winWe;
          if (w_winner == OWN_EXT) begin
            bus.mem_addr  = bus.ext_addr;
            bus.mem_wdata = bus.ext_wdata;
          end else begin
            bus.mem_addr  = bus.core_addr;
            bus.mem_wdata = bus.core_wdata;
          end
          if (!w_winWe) begin
            w_nextState = ARB_RD_WAIT;
          end
        end
      end
      ARB_RD_WAIT: begin
        bus.rdata       = bus.mem_rdata;
        bus.core_rvalid = (r_owner == OWN_CORE);
        bus.ext_rvalid  = (r_owner == OWN_EXT);
        w_nextState     = ARB_IDLE;
      end
      default: begin
        w_nextState = ARB_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rv_mem_arb.sv
// Directed bench for rv_mem_arb with a small word memory model behind the port.
// Covers the default build and, when RV_ARB_RR_EN is defined, round-robin alternation.
module tb_rv_mem_arb;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   gntIdx;

  logic [31:0] memArr [0:63];
  logic [31:0] memRdata;
  bit          memInit = 1'b0;

  rv_mem_arb_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  rv_mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes land at the grant edge, reads return on the next cycle.
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 64; i++) memArr[i] <= 32'h0;
      memArr[16] <= 32'hDEADBEEF;
      memArr[4]  <= 32'h12345678;
      memInit    <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) memArr[bus.mem_addr[7:2]] <= bus.mem_wdata;
      else            memRdata <= memArr[bus.mem_addr[7:2]];
    end
  end
  assign bus.mem_rdata = memRdata;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe, input logic [31:0] cAddr,
                               input logic [31:0] cData, input logic eReq, input logic eWe,
                               input logic [31:0] eAddr, input logic [31:0] eData);
    bus.core_req   = cReq;
    bus.core_we    = cWe;
    bus.core_addr  = cAddr;
    bus.core_wdata = cData;
    bus.ext_req    = eReq;
    bus.ext_we     = eWe;
    bus.ext_addr   = eAddr;
    bus.ext_wdata  = eData;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    memRdata = 32'h0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_core_gnt", {31'b0, bus.core_gnt}, 0);
    checkOutput("rst_ext_gnt", {31'b0, bus.ext_gnt}, 0);
    checkOutput("rst_core_rvalid", {31'b0, bus.core_rvalid}, 0);
    checkOutput("rst_ext_rvalid", {31'b0, bus.ext_rvalid}, 0);
    checkOutput("rst_mem_en", {31'b0, bus.mem_en}, 0);
    checkOutput("rst_mem_we", {31'b0, bus.mem_we}, 0);
    checkOutput("rst_mem_addr", bus.mem_addr, 0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    nextCycle();
    rst_n = 1'b1;

    // Uncontended core read
    applyStimulus(1, 0, 32'h40, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd_core_gnt", {31'b0, bus.core_gnt}, 1);
    checkOutput("rd_mem_en", {31'b0, bus.mem_en}, 1);
    checkOutput("rd_mem_we", {31'b0, bus.mem_we}, 0);
    checkOutput("rd_mem_addr", bus.mem_addr, 32'h40);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rd_core_rvalid", {31'b0, bus.core_rvalid}, 1);
    checkOutput("rd_ext_rvalid", {31'b0, bus.ext_rvalid}, 0);
    checkOutput("rd_rdata", bus.rdata, 32'hDEADBEEF);
    checkOutput("rd_wait_no_gnt", {31'b0, bus.core_gnt}, 0);
    nextCycle();

    // Back-to-back external writes, then read back 0x4
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h0, 32'h11);
    @(negedge clk);
    checkOutput("wr1_ext_gnt", {31'b0, bus.ext_gnt}, 1);
    checkOutput("wr1_mem_we", {31'b0, bus.mem_we}, 1);
    checkOutput("wr1_mem_wdata", bus.mem_wdata, 32'h11);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h4, 32'h22);
    @(negedge clk);
    checkOutput("wr2_ext_gnt", {31'b0, bus.ext_gnt}, 1);
    checkOutput("wr2_mem_addr", bus.mem_addr, 32'h4);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h4, 0);
    @(negedge clk);
    checkOutput("rb_ext_gnt", {31'b0, bus.ext_gnt}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("rb_ext_rvalid", {31'b0, bus.ext_rvalid}, 1);
    checkOutput("rb_core_rvalid", {31'b0, bus.core_rvalid}, 0);
    checkOutput("rb_rdata", bus.rdata, 32'h22);
    nextCycle();

    // Simultaneous writes: core first, ext next cycle
    applyStimulus(1, 1, 32'h8, 32'hA, 1, 1, 32'hC, 32'hB);
    @(negedge clk);
    checkOutput("sim_core_gnt", {31'b0, bus.core_gnt}, 1);
    checkOutput("sim_ext_wait", {31'b0, bus.ext_gnt}, 0);
    checkOutput("sim_wdata0", bus.mem_wdata, 32'hA);
    nextCycle();
    bus.core_req = 1'b0;
    @(negedge clk);
    checkOutput("sim_ext_gnt", {31'b0, bus.ext_gnt}, 1);
    checkOutput("sim_wdata1", bus.mem_wdata, 32'hB);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef RV_ARB_RR_EN
    applyStimulus(1, 1, 32'h20, 32'h77, 1, 1, 32'h24, 32'h55);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_core_gnt%0d", c), {31'b0, bus.core_gnt}, (c % 2 == 0) ? 1 : 0);
      checkOutput($sformatf("rr_ext_gnt%0d", c), {31'b0, bus.ext_gnt}, (c % 2 == 0) ? 0 : 1);
      nextCycle();
    end
`else
    // Starvation guard: ext forced through on the 9th cycle, twice in a row
    applyStimulus(1, 1, 32'h20, 32'h77, 1, 1, 32'h24, 32'h55);
    for (int round = 0; round < 2; round++) begin
      gntIdx = 99;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (bus.ext_gnt) begin
          gntIdx = c;
          break;
        end
        nextCycle();
      end
      checkOutput($sformatf("starve_gnt_cycle%0d", round), gntIdx, 8);
      checkOutput($sformatf("starve_core_held%0d", round), {31'b0, bus.core_gnt}, 0);
      nextCycle();
    end
    bus.ext_req = 1'b0;
    @(negedge clk);
    checkOutput("starve_core_resume", {31'b0, bus.core_gnt}, 1);
    nextCycle();
`endif
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();

    // Reset during RD_WAIT drops the pending read
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("mid_core_gnt", {31'b0, bus.core_gnt}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid_core_rvalid", {31'b0, bus.core_rvalid}, 0);
    checkOutput("mid_rdata", bus.rdata, 0);
    checkOutput("mid_mem_en", {31'b0, bus.mem_en}, 0);
    nextCycle();
    @(negedge clk);
    checkOutput("mid_core_rvalid2", {31'b0, bus.core_rvalid}, 0);
    nextCycle();
    rst_n = 1'b1;
    applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("reissue_gnt", {31'b0, bus.core_gnt}, 1);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checkOutput("reissue_rvalid", {31'b0, bus.core_rvalid}, 1);
    checkOutput("reissue_rdata", bus.rdata, 32'h12345678);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
